// File: rtl/cooler_pkg.sv
// Shared state encodings, default tuning constants and speed arithmetic
// for the closed-loop fan controller and its companion blocks.
package cooler_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_UP     = 3'd1;
   localparam logic [2:0] ST_HOLD   = 3'd2;
   localparam logic [2:0] ST_DOWN   = 3'd3;
   localparam logic [2:0] ST_CRIT   = 3'd4;
   localparam logic [2:0] ST_FAULT  = 3'd5;
   localparam logic [2:0] ST_MANUAL = 3'd6;

   localparam int HYST_DEF      = 10;
   localparam int SPEED_MIN_DEF = 20;
   localparam int SPEED_MAX_DEF = 100;
   localparam int CRIT_TEMP_DEF = 850;

   // Ramp up by step, saturating at smax; a stopped fan restarts at no less than smin.
   function automatic logic [31:0] speed_step_up(input logic [31:0] spd,
                                                 input logic [31:0] step,
                                                 input logic [31:0] smin,
                                                 input logic [31:0] smax);
      logic [31:0] nxt;
      if (spd == 32'd0) nxt = (step > smin) ? step : smin;
      else              nxt = spd + step;
      if (nxt > smax) nxt = smax;
      return nxt;
   endfunction

   // Ramp down by step; a result that would drop below smin stops the fan instead.
   // Comparing against smin+step avoids ever forming a negative intermediate.
   function automatic logic [31:0] speed_step_down(input logic [31:0] spd,
                                                   input logic [31:0] step,
                                                   input logic [31:0] smin);
      logic [31:0] nxt;
      if (spd < smin + step) nxt = 32'd0;
      else                   nxt = spd - step;
      return nxt;
   endfunction

endpackage

// File: rtl/cooler_tick_gen.sv
// Free-running control tick: one-cycle tick_o every CNT_MAX clocks.
// Latency: first tick CNT_MAX-1 cycles after reset release.
// No backpressure: the counter never stalls.
module cooler_tick_gen #(
   parameter int CNT_MAX = 5000000
) (
   input  logic clk_i,
   input  logic rstn_i,
   output logic tick_o
);

   localparam int            CW   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Advance the count, wrapping to zero after the last value.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/cooler_ctrl_temp_loop.sv
// Closed-loop fan duty controller: hysteresis, coarse/fine ramp, crit override, manual, sensor fault.
// Latency: a sample captured at tick k moves speed/state one clock later (tick_d).
// No backpressure: samples are single-cycle strobes; the newest one before a tick wins.
module cooler_ctrl_temp_loop
   import cooler_pkg::*;
#(
   parameter int TW           = 12,
   parameter int SW           = 8,
   parameter int CNT_MAX      = 5000000,
   parameter int HYST         = HYST_DEF,
   parameter int COARSE_DELTA = 50,
   parameter int STEP_FINE    = 1,
   parameter int STEP_COARSE  = 5,
   parameter int SPEED_MIN    = SPEED_MIN_DEF,
   parameter int SPEED_MAX    = SPEED_MAX_DEF,
   parameter int CRIT_TEMP    = CRIT_TEMP_DEF,
   parameter int FAULT_TICKS  = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 mode_i,
   input  logic [SW-1:0]        manual_speed_i,
   input  logic signed [TW-1:0] temp_target_i,
   input  logic signed [TW-1:0] temp_i,
   input  logic                 temp_valid_i,
   output logic [SW-1:0]        speed_o,
   output logic [2:0]           state_o,
   output logic                 at_target_o,
   output logic                 crit_alarm_o,
   output logic                 sensor_fault_o
);

   localparam int                   FW        = $clog2(FAULT_TICKS + 1);
   localparam logic [FW-1:0]        FAULT_LIM = FW'(FAULT_TICKS);
   localparam logic [TW:0]          HYST_IN   = (TW+1)'(HYST);
   localparam logic [TW:0]          HYST_OUT  = (TW+1)'(2 * HYST);
   localparam logic [TW:0]          COARSE_W  = (TW+1)'(COARSE_DELTA);
   localparam logic signed [TW-1:0] CRIT_ON   = TW'(CRIT_TEMP);
   localparam logic signed [TW-1:0] CRIT_OFF  = TW'(CRIT_TEMP - HYST);
   localparam logic [SW-1:0]        SMAX      = SW'(SPEED_MAX);

   logic                 tick;
   logic                 tick_d_q;
   logic signed [TW-1:0] pend_q;
   logic                 pend_v_q;
   logic signed [TW-1:0] cur_temp_q;
   logic [FW-1:0]        fault_cnt_q;
   logic [2:0]           state_q, state_d;
   logic [SW-1:0]        speed_q, speed_d;
   logic signed [TW:0]   delta;
   logic [TW:0]          delta_mag;
   logic [SW-1:0]        step;
   logic [SW-1:0]        manual_clamped;
   logic                 in_band;
   logic                 crit_now;

   cooler_tick_gen #(
      .CNT_MAX (CNT_MAX)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tick_o (tick)
   );

   // One extra bit keeps the difference of two extreme temperatures exact.
   assign delta     = $signed({cur_temp_q[TW-1], cur_temp_q}) -
                      $signed({temp_target_i[TW-1], temp_target_i});
   assign delta_mag = delta[TW] ? $unsigned(-delta) : $unsigned(delta);

   // Capture strobed samples, hand the freshest to the loop on each tick, count empty ticks.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tick_d_q    <= 1'b0;
         pend_q      <= '0;
         pend_v_q    <= 1'b0;
         cur_temp_q  <= '0;
         fault_cnt_q <= '0;
      end else begin
         tick_d_q <= tick;
         if (tick) begin
            // A strobe landing on the tick itself is newer than anything pending.
            if (temp_valid_i) begin
               cur_temp_q  <= temp_i;
               pend_v_q    <= 1'b0;
               fault_cnt_q <= '0;
            end else if (pend_v_q) begin
               cur_temp_q  <= pend_q;
               pend_v_q    <= 1'b0;
               fault_cnt_q <= '0;
            end else if (fault_cnt_q != FAULT_LIM) begin
               fault_cnt_q <= fault_cnt_q + FW'(1);
            end
         end else if (temp_valid_i) begin
            pend_q   <= temp_i;
            pend_v_q <= 1'b1;
         end
      end
   end

   // Decide next state and duty; disable wins on any cycle, everything else waits for tick_d.
   always_comb begin
      state_d        = state_q;
      speed_d        = speed_q;
      step           = (delta_mag >= COARSE_W) ? SW'(STEP_COARSE) : SW'(STEP_FINE);
      manual_clamped = (manual_speed_i > SMAX) ? SMAX : manual_speed_i;
      // Once in HOLD the band widens so small wobbles do not cause hunting.
      in_band        = (state_q == ST_HOLD) ? (delta_mag < HYST_OUT) : (delta_mag < HYST_IN);
      crit_now       = (cur_temp_q >= CRIT_ON) ||
                       ((state_q == ST_CRIT) && (cur_temp_q >= CRIT_OFF));
      if (!en_i) begin
         state_d = ST_IDLE;
         speed_d = '0;
      end else if (tick_d_q) begin
         if (fault_cnt_q == FAULT_LIM) begin
            state_d = ST_FAULT;
            speed_d = SMAX;
         end else if (crit_now) begin
            state_d = ST_CRIT;
            speed_d = SMAX;
         end else if (mode_i) begin
            state_d = ST_MANUAL;
            speed_d = manual_clamped;
         end else if (in_band) begin
            state_d = ST_HOLD;
         end else if (!delta[TW]) begin
            state_d = ST_UP;
            speed_d = SW'(speed_step_up(32'(speed_q), 32'(step),
                                        32'(SPEED_MIN), 32'(SPEED_MAX)));
         end else begin
            state_d = ST_DOWN;
            speed_d = SW'(speed_step_down(32'(speed_q), 32'(step), 32'(SPEED_MIN)));
         end
      end
   end

   // State and duty registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         speed_q <= '0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
      end
   end

   assign speed_o        = speed_q;
   assign state_o        = state_q;
   assign at_target_o    = (state_q == ST_HOLD);
   assign crit_alarm_o   = (state_q == ST_CRIT);
   assign sensor_fault_o = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cooler_ctrl_temp_loop.sv
// Self-checking bench for cooler_ctrl_temp_loop with a short control period.
// Directed scenarios followed by random periods against a per-period reference model.
// Outputs are sampled on the falling clock edge.
module tb_cooler_ctrl_temp_loop;

   localparam int TW      = 12;
   localparam int SW      = 8;
   localparam int CNT_MAX = 4;

   localparam int R_HYST      = 10;
   localparam int R_COARSE_TH = 50;
   localparam int R_FINE      = 1;
   localparam int R_COARSE    = 5;
   localparam int R_SMIN      = 20;
   localparam int R_SMAX      = 100;
   localparam int R_CRIT      = 850;
   localparam int R_FT        = 4;

   localparam int S_IDLE = 0, S_UP = 1, S_HOLD = 2, S_DOWN = 3,
                  S_CRIT = 4, S_FAULT = 5, S_MANUAL = 6;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 en;
   logic                 mode;
   logic [SW-1:0]        manual_speed;
   logic signed [TW-1:0] temp_target;
   logic signed [TW-1:0] temp;
   logic                 temp_valid;
   logic [SW-1:0]        speed;
   logic [2:0]           state;
   logic                 at_target;
   logic                 crit_alarm;
   logic                 sensor_fault;

   int checks = 0;
   int errors = 0;

   // control inputs as the model sees them
   int c_en, c_mode, c_man, c_tgt;
   // reference model state
   int m_state, m_speed, m_cur, m_pend, m_pend_v, m_fault;

   cooler_ctrl_temp_loop #(
      .TW      (TW),
      .SW      (SW),
      .CNT_MAX (CNT_MAX)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .en_i           (en),
      .mode_i         (mode),
      .manual_speed_i (manual_speed),
      .temp_target_i  (temp_target),
      .temp_i         (temp),
      .temp_valid_i   (temp_valid),
      .speed_o        (speed),
      .state_o        (state),
      .at_target_o    (at_target),
      .crit_alarm_o   (crit_alarm),
      .sensor_fault_o (sensor_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " speed"},        32'(speed),        32'(m_speed));
      check({tag, " state"},        32'(state),        32'(m_state));
      check({tag, " at_target"},    32'(at_target),    32'(m_state == S_HOLD));
      check({tag, " crit_alarm"},   32'(crit_alarm),   32'(m_state == S_CRIT));
      check({tag, " sensor_fault"}, 32'(sensor_fault), 32'(m_state == S_FAULT));
   endtask

   task automatic set_ctl(input int e, input int md, input int man, input int tgt);
      c_en = e; c_mode = md; c_man = man; c_tgt = tgt;
      en = (e != 0); mode = (md != 0);
      manual_speed = SW'(man); temp_target = TW'(tgt);
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_speed = 0; m_cur = 0; m_pend = 0; m_pend_v = 0; m_fault = 0;
   endtask

   // One control period: sample bookkeeping at the tick, then the control decision.
   task automatic model_period(input int v, input int t, input int slot);
      int d, a, stp, band;
      if (v != 0 && slot <= 2) begin
         m_cur = t; m_pend_v = 0; m_fault = 0;
      end else if (m_pend_v != 0) begin
         m_cur = m_pend; m_pend_v = 0; m_fault = 0;
      end else if (m_fault < R_FT) begin
         m_fault++;
      end
      if (v != 0 && slot == 3) begin
         m_pend = t; m_pend_v = 1;
      end
      d    = m_cur - c_tgt;
      a    = (d < 0) ? -d : d;
      stp  = (a >= R_COARSE_TH) ? R_COARSE : R_FINE;
      band = (m_state == S_HOLD) ? 2 * R_HYST : R_HYST;
      if (c_en == 0) begin
         m_state = S_IDLE; m_speed = 0;
      end else if (m_fault == R_FT) begin
         m_state = S_FAULT; m_speed = R_SMAX;
      end else if (m_cur >= R_CRIT || (m_state == S_CRIT && m_cur >= R_CRIT - R_HYST)) begin
         m_state = S_CRIT; m_speed = R_SMAX;
      end else if (c_mode != 0) begin
         m_state = S_MANUAL; m_speed = (c_man > R_SMAX) ? R_SMAX : c_man;
      end else if (a < band) begin
         m_state = S_HOLD;
      end else if (d > 0) begin
         m_state = S_UP;
         if (m_speed == 0) m_speed = (stp > R_SMIN) ? stp : R_SMIN;
         else              m_speed = (m_speed + stp > R_SMAX) ? R_SMAX : m_speed + stp;
      end else begin
         m_state = S_DOWN;
         m_speed = (m_speed - stp < R_SMIN) ? 0 : m_speed - stp;
      end
   endtask

   // Drive one clock cycle's inputs from a falling edge to the next falling edge.
   task automatic drive_cycle(input int v, input int t);
      temp_valid = (v != 0);
      temp       = TW'(t);
      @(posedge clk);
      @(negedge clk);
      temp_valid = 1'b0;
   endtask

   // Slots 0..3 are the cycles with counter 1,2,3(tick),0(tick_d); slot 3 becomes pending.
   task automatic ctrl_period(input int v, input int t, input int slot);
      for (int c = 0; c < 4; c++) drive_cycle((v != 0 && c == slot) ? 1 : 0, t);
      model_period(v, t, slot);
   endtask

   initial begin
      rstn = 1'b0; temp_valid = 1'b0; temp = '0;
      set_ctl(0, 0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");

      // release; the first cycle after release has counter 0
      rstn = 1'b1;
      set_ctl(1, 0, 0, 250);
      drive_cycle(0, 0);

      // coarse ramp from standstill: floor first, then +5 up to saturation
      for (int i = 0; i < 18; i++) begin
         ctrl_period(1, 400, 0);
         check_outputs("ramp");
         if (i == 0) check("ramp floor", 32'(speed), 32'd20);
      end
      check("ramp saturate", 32'(speed), 32'd100);

      // small error uses the fine step
      ctrl_period(1, 230, 1);
      check_outputs("fine");
      check("fine step", 32'(speed), 32'd99);

      // park at 50 via manual, then hysteresis band behaviour
      set_ctl(1, 1, 50, 250);
      ctrl_period(1, 230, 0);
      check_outputs("manual50");
      set_ctl(1, 0, 50, 250);
      ctrl_period(1, 255, 0);
      check_outputs("hold enter");
      check("hold at_target", 32'(at_target), 32'd1);
      check("hold speed", 32'(speed), 32'd50);
      ctrl_period(1, 265, 1);
      check_outputs("hold stay 15");
      ctrl_period(1, 269, 2);
      check_outputs("hold stay 19");
      ctrl_period(1, 270, 0);
      check_outputs("hold leave 20");
      ctrl_period(1, 255, 0);
      check_outputs("hold reenter");

      // fine ramp down to the floor, then stop without wrap
      for (int i = 0; i < 60 && m_speed != 0; i++) begin
         ctrl_period(1, 230, 0);
         check_outputs("down");
      end
      check("floor to zero", 32'(speed), 32'd0);
      ctrl_period(1, 230, 0);
      check_outputs("down at zero");
      check("no wrap", 32'(speed), 32'd0);

      // critical override beats manual, exits below the lower threshold
      set_ctl(1, 1, 30, 250);
      ctrl_period(1, 860, 0);
      check_outputs("crit enter");
      check("crit alarm", 32'(crit_alarm), 32'd1);
      ctrl_period(1, 845, 0);
      check_outputs("crit stay 845");
      ctrl_period(1, 841, 3);
      check_outputs("crit stay 841");
      ctrl_period(1, 839, 0);
      check_outputs("crit exit");
      check("crit exit state", 32'(state), 32'(S_MANUAL));
      check("crit exit speed", 32'(speed), 32'd30);
      set_ctl(1, 1, 200, 250);
      ctrl_period(1, 500, 0);
      check_outputs("manual clamp");

      // sensor timeout and recovery
      set_ctl(1, 0, 0, 250);
      ctrl_period(1, 250, 0);
      check_outputs("pre fault");
      for (int i = 0; i < 4; i++) begin
         ctrl_period(0, 0, 0);
         check_outputs("silent");
      end
      check("fault flag", 32'(sensor_fault), 32'd1);
      check("fault speed", 32'(speed), 32'd100);
      ctrl_period(1, 250, 1);
      check_outputs("fault recover");
      check("recover state", 32'(state), 32'(S_HOLD));

      // sample on the tick cycle overrides a pending one and leaves nothing pending
      ctrl_period(1, 600, 3);
      check_outputs("pend 600");
      ctrl_period(1, 260, 2);
      check_outputs("coincident");
      check("coincident hold", 32'(at_target), 32'd1);
      for (int i = 0; i < 4; i++) begin
         ctrl_period(0, 0, 0);
         check_outputs("no stale pend");
      end
      ctrl_period(1, 400, 0);
      check_outputs("ramp again");
      ctrl_period(1, 400, 0);
      check_outputs("ramp again");

      // disable mid-ramp takes effect on the next clock
      set_ctl(0, 0, 0, 250);
      drive_cycle(0, 0);
      check("disable speed", 32'(speed), 32'd0);
      check("disable state", 32'(state), 32'(S_IDLE));
      for (int c = 0; c < 3; c++) drive_cycle(0, 0);
      model_period(0, 0, 0);
      check_outputs("disabled");
      set_ctl(1, 0, 0, 250);
      ctrl_period(1, 400, 0);
      check_outputs("reenable");
      ctrl_period(1, 400, 0);
      check_outputs("reenable");

      // asynchronous reset between ticks
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_outputs("async reset");
      @(negedge clk);
      rstn = 1'b1;
      drive_cycle(0, 0);

      // random periods
      for (int i = 0; i < 150; i++) begin
         int tgt, t, v, slot;
         tgt  = int'($urandom_range(0, 1100)) - 200;
         if ($urandom_range(0, 4) == 0) t = int'($urandom_range(780, 900));
         else                           t = tgt + int'($urandom_range(0, 400)) - 200;
         v    = ($urandom_range(0, 9) != 0) ? 1 : 0;
         slot = int'($urandom_range(0, 3));
         set_ctl(($urandom_range(0, 19) != 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 255)), tgt);
         ctrl_period(v, t, slot);
         check_outputs("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
